mem_block_engine: RTL and testbench

- Bus-initiator block: drives the toggle-handshake memory port (addr/cmd/run/wr_data in; rd_data/done back) from the initiator side.
- Executes block FILL, COPY and CHECK operations over a word range, so memory can be initialised, moved or verified without CPU instructions.
- Sits beside the CPU on the memory port through an external arbiter that grants one initiator at a time; the arbiter is out of scope.
- Results (error count, first-error address) are exposed for the 7-segment frame.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_req_port.sv | 70 +++++++
 rtl/mem_block_engine.sv | 145 ++++++++++++++
 tb/tb_mem_block_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared command, operation and state encodings for the block engine
package mem_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        COPY  = 2'b01,
        CHECK = 2'b10,
        RSVD  = 2'b11
    } eng_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        WAIT_RD,
        ISSUE_WR,
        WAIT_WR,
        NEXT,
        FINISH
    } eng_state_t;

endpackage

// File: rtl/mem_req_port.sv
// mem_req_port: toggle-handshake initiator port holding one request at a time
// Ports:
//   issue/cmd/addr/wdata - launch a request (registered, mem_run toggles)
//   clr                  - return mem_cmd to nop once the operation ends
//   idle                 - no request outstanding (mem_run == mem_done)
//   rd_valid             - first cycle the outstanding request has completed
//   rd_data              - read word captured at completion
//   mem_*                - memory port signals
module mem_req_port import mem_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue,
    input  logic              clr,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              idle,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic              mem_run,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_done
);

    mem_cmd_t          cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              run_q;
    logic              pend_q;

    assign idle        = run_q == mem_done;
    // pend_q marks a request we launched, so completion is seen exactly once
    assign rd_valid    = pend_q && idle;
    assign rd_data     = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_cmd     = cmd_q;
    assign mem_run     = run_q;
    assign mem_wr_data = wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (issue) begin
            cmd_q   <= mem_cmd_t'(cmd);
            addr_q  <= addr;
            wdata_q <= wdata;
            run_q   <= ~run_q;
            pend_q  <= 1'b1;
        end else if (rd_valid) begin
            pend_q  <= 1'b0;
            if (cmd_q == READ)
                rdata_q <= mem_rd_data;
        end else if (clr) begin
            cmd_q   <= NOP;
        end
    end

endmodule

// File: rtl/mem_block_engine.sv
// mem_block_engine: FILL/COPY/CHECK block engine driving the toggle-handshake memory port
// Ports:
//   start/op/src/dst/len/pattern/pat_inc - operation request, sampled in IDLE
//   busy/op_done                         - progress and one-cycle completion pulse
//   err_count/first_err_addr/err         - CHECK results
//   mem_*                                - initiator side of the memory port
module mem_block_engine import mem_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] pattern,
    input  logic              pat_inc,
    output logic              busy,
    output logic              op_done,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic              mem_run,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_done
);

    eng_state_t        state_q, state_d;
    eng_op_t           op_q, op_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, first_q, first_d;
    logic [CNT_W-1:0]  rem_q, rem_d, err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              inc_q, inc_d;
    logic              op_done_q;
    logic              port_idle, rd_valid;
    logic [DATA_W-1:0] rd_word;

    mem_req_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue       (state_q == ISSUE_RD || state_q == ISSUE_WR),
        .clr         (state_q == FINISH),
        .cmd         (state_q == ISSUE_RD ? READ : WRITE),
        .addr        (state_q == ISSUE_RD ? rd_ptr_q : wr_ptr_q),
        .wdata       (op_q == COPY ? rd_word : pat_q),
        .idle        (port_idle),
        .rd_valid    (rd_valid),
        .rd_data     (rd_word),
        .mem_addr    (mem_addr),
        .mem_cmd     (mem_cmd),
        .mem_run     (mem_run),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_done    (mem_done)
    );

    assign busy           = state_q != IDLE && state_q != FINISH;
    assign op_done        = op_done_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_q;
    assign err            = |err_cnt_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rem_d     = rem_q;
        pat_d     = pat_q;
        inc_d     = inc_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        case (state_q)
            IDLE: if (start && port_idle) begin
                op_d     = eng_op_t'(op);
                rd_ptr_d = src;
                wr_ptr_d = dst;
                rem_d    = len;
                pat_d    = pattern;
                inc_d    = pat_inc;
                if (eng_op_t'(op) == CHECK) begin
                    err_cnt_d = '0;
                    first_d   = '0;
                end
                state_d = (len == '0 || eng_op_t'(op) == RSVD) ? FINISH :
                          eng_op_t'(op) == FILL ? ISSUE_WR : ISSUE_RD;
            end
            ISSUE_RD: state_d = WAIT_RD;
            WAIT_RD: if (rd_valid) begin
                if (op_q == CHECK && mem_rd_data != pat_q) begin
                    // saturate instead of wrapping so a full counter never reads as clean
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == '0)
                        first_d = rd_ptr_q;
                end
                state_d = op_q == COPY ? ISSUE_WR : NEXT;
            end
            ISSUE_WR: state_d = WAIT_WR;
            WAIT_WR:  state_d = rd_valid ? NEXT : WAIT_WR;
            NEXT: begin
                rem_d    = rem_q - 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                pat_d    = inc_q ? pat_q + 1'b1 : pat_q;
                state_d  = rem_q == CNT_W'(1) ? FINISH : op_q == FILL ? ISSUE_WR : ISSUE_RD;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= FILL;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rem_q     <= '0;
            pat_q     <= '0;
            inc_q     <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
            op_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rem_q     <= rem_d;
            pat_q     <= pat_d;
            inc_q     <= inc_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            op_done_q <= state_q == FINISH;
        end
    end

endmodule

// File: tb/tb_mem_block_engine.sv
// tb_mem_block_engine: directed checks of the block engine against a toggle-handshake memory model
module tb_mem_block_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] src = '0, dst = '0, len = '0, pattern = '0;
    logic        pat_inc = 1'b0;
    logic        busy, op_done, err;
    logic [15:0] err_count, first_err_addr, mem_addr, mem_wr_data;
    logic [1:0]  mem_cmd;
    logic        mem_run;
    logic [15:0] mem_rd_data = '0;
    logic        mem_done = 1'b0;

    logic [15:0] mem [0:65535];
    int checks = 0, errors = 0, toggles = 0, stab_viol = 0;
    int lat_mode = 0, rcnt = 0, rtgt = 1, cyc = 0;
    bit found = 0;

    mem_block_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .pat_inc(pat_inc), .busy(busy), .op_done(op_done),
        .err_count(err_count), .first_err_addr(first_err_addr), .err(err),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_run(mem_run), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    // responder: lat_mode 0 = completes within the issue cycle, 1 = random 1..5 cycles, 2 = 5 cycles
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_done = 1'b0;
            rcnt = 0;
        end else if (mem_run != mem_done) begin
            if (rcnt == 0)
                rtgt = lat_mode == 1 ? int'($urandom_range(5, 1)) : lat_mode == 2 ? 5 : 1;
            rcnt++;
            if (rcnt >= rtgt) begin
                if (mem_cmd == 2'b01)
                    mem_rd_data = mem[mem_addr];
                else if (mem_cmd == 2'b10)
                    mem[mem_addr] = mem_wr_data;
                mem_done = ~mem_done;
                rcnt = 0;
            end
        end
    end

    logic [15:0] h_addr = '0, h_data = '0;
    logic [1:0]  h_cmd = '0;
    logic        h_out = 1'b0, h_run = 1'b0;
    always @(posedge clk) begin
        if (h_out && reset_n && mem_run == h_run &&
            (mem_addr !== h_addr || mem_cmd !== h_cmd || mem_wr_data !== h_data))
            stab_viol++;
        h_out  = reset_n && (mem_run != mem_done);
        h_run  = mem_run;
        h_addr = mem_addr;
        h_cmd  = mem_cmd;
        h_data = mem_wr_data;
    end

    always @(mem_run) toggles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // launches one operation and returns the cycle (1 = cycle after start) where op_done is seen
    task automatic run_op(input logic [1:0] o, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [15:0] p, input logic inc,
                          input bit poke, output int n_done);
        op = o; src = s; dst = d; len = l; pattern = p; pat_inc = inc;
        start = 1'b1;
        toggles = 0;
        n_done = -1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            pattern = ~p;
            len = 16'h0000;
            if (poke && n == 3) begin
                start = 1'b1;
                op = 2'b00;
                dst = 16'h0200;
                len = 16'd2;
            end
            if (n == 1)
                chk("busy_after_start", 32'(busy), 32'(l != 0 && o != 2'b11));
            if (op_done) begin
                n_done = n;
                break;
            end
        end
        chk("op_done_seen", 32'(n_done > 0), 1);
        chk("busy_at_done", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hDEAD;
        #12;
        chk("rst_status", {busy, op_done, err, mem_run, mem_cmd}, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 16'h0000, 16'h0010, 16'd4, 16'hA5A5, 1'b1, 1'b0, cyc);
        chk("fill_cycles", cyc, 14);
        chk("fill_toggles", toggles, 4);
        for (int i = 0; i < 4; i++) chk("fill_mem", mem[16'h0010 + i], 16'hA5A5 + i);
        chk("fill_err", 32'(err), 0);

        run_op(2'b01, 16'h0010, 16'h0100, 16'd4, 16'h0000, 1'b0, 1'b0, cyc);
        chk("copy_cycles", cyc, 22);
        chk("copy_toggles", toggles, 8);
        for (int i = 0; i < 4; i++) chk("copy_mem", mem[16'h0100 + i], 16'hA5A5 + i);
        @(posedge clk); #1;
        chk("copy_busy_after", 32'(busy), 0);

        mem[16'h0012] = 16'h0000;
        run_op(2'b10, 16'h0010, 16'h0000, 16'd4, 16'hA5A5, 1'b1, 1'b0, cyc);
        chk("check_cycles", cyc, 14);
        chk("check_err_count", err_count, 1);
        chk("check_first_err", first_err_addr, 16'h0012);
        chk("check_err", 32'(err), 1);

        run_op(2'b00, 16'h0000, 16'hFFFE, 16'd3, 16'h1234, 1'b0, 1'b1, cyc);
        chk("wrap_cycles", cyc, 11);
        chk("wrap_fffe", mem[16'hFFFE], 16'h1234);
        chk("wrap_ffff", mem[16'hFFFF], 16'h1234);
        chk("wrap_0000", mem[16'h0000], 16'h1234);
        chk("wrap_fffd_untouched", mem[16'hFFFD], 16'hDEAD);
        chk("wrap_0001_untouched", mem[16'h0001], 16'hDEAD);
        chk("ignored_start_no_write", mem[16'h0200], 16'hDEAD);
        chk("fill_keeps_err_count", err_count, 1);

        run_op(2'b00, 16'h0000, 16'h0700, 16'd0, 16'h5555, 1'b0, 1'b0, cyc);
        chk("len0_cycles", cyc, 2);
        chk("len0_toggles", toggles, 0);
        chk("len0_no_write", mem[16'h0700], 16'hDEAD);

        run_op(2'b11, 16'h0010, 16'h0700, 16'd4, 16'h5555, 1'b0, 1'b0, cyc);
        chk("rsvd_cycles", cyc, 2);
        chk("rsvd_toggles", toggles, 0);

        lat_mode = 1;
        stab_viol = 0;
        run_op(2'b00, 16'h0000, 16'h0300, 16'd4, 16'h0F00, 1'b1, 1'b0, cyc);
        run_op(2'b01, 16'h0300, 16'h0400, 16'd4, 16'h0000, 1'b0, 1'b0, cyc);
        chk("rand_copy_toggles", toggles, 8);
        for (int i = 0; i < 4; i++) chk("rand_copy_mem", mem[16'h0400 + i], 16'h0F00 + i);
        run_op(2'b10, 16'h0400, 16'h0000, 16'd4, 16'h0F00, 1'b1, 1'b0, cyc);
        chk("rand_check_err_count", err_count, 0);
        chk("rand_check_first_err", first_err_addr, 0);
        chk("rand_stable_request", stab_viol, 0);

        lat_mode = 2;
        op = 2'b01; src = 16'h0010; dst = 16'h0500; len = 16'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int n = 0; n < 60; n++) begin
            if (mem_cmd == 2'b10 && mem_run != mem_done) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reached_wait_wr", 32'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_status", {busy, op_done, err, mem_run, mem_cmd}, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wr_data", mem_wr_data, 0);
        chk("abort_no_write", mem[16'h0500], 16'hDEAD);
        #20;
        @(posedge clk); #1 reset_n = 1'b1;
        lat_mode = 0;
        @(posedge clk); #1;
        run_op(2'b00, 16'h0000, 16'h0600, 16'd2, 16'h7777, 1'b1, 1'b0, cyc);
        chk("post_reset_cycles", cyc, 8);
        chk("post_reset_mem0", mem[16'h0600], 16'h7777);
        chk("post_reset_mem1", mem[16'h0601], 16'h7778);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
